// File: rtl/cfg_chain_loader.sv
// Dual-bank configuration chain loader: takes host words, shifts CHAIN_LEN bits onto chains A/B.
// Optional CRC-16 readback signature of the chain tails when CFG_READBACK_EN is defined.
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 30,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              chain_en,
    output logic              chain_dinA,
    output logic              chain_dinB,
    input  logic              chain_doutA,
    input  logic              chain_doutB,
    output logic              busy,
    output logic              done,
    output logic              loaded
`ifdef CFG_READBACK_EN
    ,
    output logic [15:0]       sig
`endif
);

    localparam int HALF_W = WORD_W / 2;
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W  = $clog2(HALF_W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HALF_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] SHIFT  = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [HALF_W-1:0] buf_a_reg, buf_a_next;
    logic [HALF_W-1:0] buf_b_reg, buf_b_next;
    logic              en_reg, en_next;
    logic              din_a_reg, din_a_next;
    logic              din_b_reg, din_b_next;
    logic              done_reg, done_next;
    logic              loaded_reg, loaded_next;
    logic              start_accept;

    // abort has priority over a simultaneous start while idle
    assign start_accept = (state_reg == IDLE) && start && !abort;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        buf_a_next  = buf_a_reg;
        buf_b_next  = buf_b_reg;
        en_next     = 1'b0;
        din_a_next  = 1'b0;
        din_b_next  = 1'b0;
        done_next   = 1'b0;
        loaded_next = loaded_reg;

        if (abort && (state_reg != IDLE)) begin
            state_next  = IDLE;
            loaded_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_accept) begin
                        state_next  = LOAD;
                        loaded_next = 1'b0;
                        cnt_next    = '0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        // first bit goes out the very next cycle; buffers hold the rest
                        state_next = SHIFT;
                        idx_next   = '0;
                        en_next    = 1'b1;
                        din_a_next = cfg_word[0];
                        din_b_next = cfg_word[HALF_W];
                        buf_a_next = cfg_word[HALF_W-1:0] >> 1;
                        buf_b_next = cfg_word[WORD_W-1:HALF_W] >> 1;
                    end
                end
                SHIFT: begin
                    cnt_next = cnt_reg + CNT_ONE;
                    idx_next = idx_reg + IDX_ONE;
                    if (cnt_reg == CNT_LAST) begin
                        state_next  = FINISH;
                        done_next   = 1'b1;
                        loaded_next = 1'b1;
                    end else if (idx_reg == IDX_LAST) begin
                        state_next = LOAD;
                    end else begin
                        en_next    = 1'b1;
                        din_a_next = buf_a_reg[0];
                        din_b_next = buf_b_reg[0];
                        buf_a_next = buf_a_reg >> 1;
                        buf_b_next = buf_b_reg >> 1;
                    end
                end
                FINISH: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            buf_a_reg  <= '0;
            buf_b_reg  <= '0;
            en_reg     <= 1'b0;
            din_a_reg  <= 1'b0;
            din_b_reg  <= 1'b0;
            done_reg   <= 1'b0;
            loaded_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            buf_a_reg  <= buf_a_next;
            buf_b_reg  <= buf_b_next;
            en_reg     <= en_next;
            din_a_reg  <= din_a_next;
            din_b_reg  <= din_b_next;
            done_reg   <= done_next;
            loaded_reg <= loaded_next;
        end
    end

    assign cfg_ready  = (state_reg == LOAD);
    assign busy       = (state_reg != IDLE);
    assign chain_en   = en_reg;
    assign chain_dinA = din_a_reg;
    assign chain_dinB = din_b_reg;
    assign done       = done_reg;
    assign loaded     = loaded_reg;

`ifdef CFG_READBACK_EN
    logic [15:0] sig_reg;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // chain A tail is folded in before chain B tail on every shift cycle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sig_reg <= 16'hFFFF;
        end else if (start_accept) begin
            sig_reg <= 16'hFFFF;
        end else if (en_reg) begin
            sig_reg <= crc_step(crc_step(sig_reg, chain_doutA), chain_doutB);
        end
    end

    assign sig = sig_reg;
`else
    logic unused_dout;
    assign unused_dout = chain_doutA ^ chain_doutB;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: directed scenarios with random words checked
// against a stream model; readback signature checked when CFG_READBACK_EN is defined.
module tb_cfg_chain_loader;

    localparam int CL = 30;
    localparam int WW = 32;
    localparam int HW = WW / 2;
    localparam int NW = (CL + HW - 1) / HW;

    logic        clk = 1'b0;
    logic        nrst, start, abort, cfg_valid;
    logic [31:0] cfg_word;
    logic        cfg_ready, chain_en, chain_dinA, chain_dinB;
    logic        chain_doutA, chain_doutB;
    logic        busy, done, loaded;
`ifdef CFG_READBACK_EN
    logic [15:0] sig;
`endif

    cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .chain_en(chain_en), .chain_dinA(chain_dinA), .chain_dinB(chain_dinB),
        .chain_doutA(chain_doutA), .chain_doutB(chain_doutB),
        .busy(busy), .done(done), .loaded(loaded)
`ifdef CFG_READBACK_EN
        , .sig(sig)
`endif
    );

    always #5 clk = ~clk;

    // behavioural model of the two external chains
    logic [CL-1:0] chain_a = '0;
    logic [CL-1:0] chain_b = '0;
    always @(posedge clk) begin
        if (chain_en) begin
            chain_a <= {chain_a[CL-2:0], chain_dinA};
            chain_b <= {chain_b[CL-2:0], chain_dinB};
        end
    end
    assign chain_doutA = chain_a[CL-1];
    assign chain_doutB = chain_b[CL-1];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          en_cnt, done_cnt, hs_cnt;
    int          en_cyc[$];
    bit          qa[$], qb[$];
    logic [31:0] host_q[$];
    logic [31:0] exp_w[NW];
    bit          host_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        en_cnt = 0; done_cnt = 0; hs_cnt = 0;
        en_cyc.delete(); qa.delete(); qb.delete();
    endtask

    // one clock: observe at negedge, advance host after the rising edge
    task automatic step();
        bit hs;
        @(negedge clk);
        cyc++;
        hs = cfg_valid && cfg_ready;
        if (chain_en) begin
            qa.push_back(chain_dinA);
            qb.push_back(chain_dinB);
            en_cyc.push_back(cyc);
            en_cnt++;
        end
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        if (hs) begin
            hs_cnt++;
            if (host_q.size() > 0) void'(host_q.pop_front());
        end
        cfg_word  = (host_q.size() > 0) ? host_q[0] : $urandom;
        cfg_valid = host_valid;
    endtask

    task automatic run_until_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    endtask

    function automatic logic [31:0] model_stream(input bit bank_b);
        logic [31:0] s = '0;
        for (int k = 0; k < CL; k++) begin
            logic [31:0] w = exp_w[k / HW];
            s[k] = w[(bank_b ? HW : 0) + (k % HW)];
        end
        return s;
    endfunction

    function automatic logic [31:0] got_stream(input bit bank_b);
        logic [31:0] s = '0;
        for (int i = 0; i < 32; i++) begin
            if (bank_b && i < qb.size()) s[i] = qb[i];
            if (!bank_b && i < qa.size()) s[i] = qa[i];
        end
        return s;
    endfunction

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic arm(input logic [31:0] w0, input logic [31:0] w1, input bit v);
        clear_mon();
        host_q.delete();
        host_q.push_back(w0);
        host_q.push_back(w1);
        exp_w[0] = w0;
        exp_w[1] = w1;
        cfg_word = w0;
        host_valid = v;
        cfg_valid = v;
    endtask

    task automatic do_load(input string tag, input logic [31:0] w0, input logic [31:0] w1);
        arm(w0, w1, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_done(tag);
        chk({tag, "_shifts"}, en_cnt, CL);
        chk({tag, "_streamA"}, got_stream(1'b0), model_stream(1'b0));
        chk({tag, "_streamB"}, got_stream(1'b1), model_stream(1'b1));
        chk({tag, "_loaded"}, {busy, loaded}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_word = '0;
        host_valid = 1'b0;
        #1;
        chk("reset_outputs", {busy, cfg_ready, chain_en, chain_dinA, chain_dinB, done, loaded}, 7'd0);
`ifdef CFG_READBACK_EN
        chk("reset_sig", sig, 16'hFFFF);
`endif
        @(posedge clk); @(posedge clk); #1;
        nrst = 1'b1;
        step(); step();
        chk("idle_after_reset", {busy, cfg_ready, chain_en}, 3'd0);

        // nominal load with valid held high
        do_load("nominal", 32'h5555_AAAA, 32'h0000_3FFF);
        chk("nominal_A_const", got_stream(1'b0), 32'h3FFF_AAAA);
        chk("nominal_B_const", got_stream(1'b1), 32'h0000_5555);
        chk("nominal_span", en_cyc[CL-1] - en_cyc[0], CL);
        chk("nominal_bubble", en_cyc[HW] - en_cyc[HW-1], 2);
        for (int i = 0; i < 4; i++) step();
        chk("nominal_words_taken", hs_cnt, 2);
        chk("nominal_done_once", done_cnt, 1);
        chk("nominal_not_ready", cfg_ready, 1'b0);

        // host stall before the first word
        arm($urandom, $urandom, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("stall_c%0d", i), {cfg_ready, busy, chain_en}, 3'b110);
        end
        host_valid = 1'b1;
        cfg_valid = 1'b1;
        step();
        chk("stall_resume", chain_en, 1'b1);
        run_until_done("stall");
        chk("stall_shifts", en_cnt, CL);
        chk("stall_streamA", got_stream(1'b0), model_stream(1'b0));
        chk("stall_streamB", got_stream(1'b1), model_stream(1'b1));

        // abort part way through
        arm($urandom, $urandom, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100 && en_cnt < 20; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_outputs", {chain_en, busy, done, loaded}, 4'd0);
        for (int i = 0; i < 5; i++) step();
        chk("abort_shifts", en_cnt, 21);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_loaded", loaded, 1'b0);
        do_load("after_abort", $urandom, $urandom);

        // start pulsed while busy is ignored
        arm($urandom, $urandom, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100 && en_cnt < 5; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_done("busy_start");
        for (int i = 0; i < 5; i++) step();
        chk("busy_start_shifts", en_cnt, CL);
        chk("busy_start_done", done_cnt, 1);
        chk("busy_start_idle", busy, 1'b0);

        // abort and start together while idle
        arm($urandom, $urandom, 1'b1);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("abort_start_idle", {busy, cfg_ready}, 2'b00);
        chk("abort_start_shifts", en_cnt, 0);

        // asynchronous reset in the middle of shifting
        arm($urandom, $urandom, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100 && en_cnt < 8; i++) step();
        chk("pre_reset_shifting", {busy, chain_en}, 2'b11);
        #2 nrst = 1'b0;
        #1;
        chk("async_reset_outputs", {busy, cfg_ready, chain_en, chain_dinA, chain_dinB, done, loaded}, 7'd0);
        @(negedge clk);
        nrst = 1'b1;
        clear_mon();
        for (int i = 0; i < 4; i++) step();
        chk("post_reset_idle", {busy, en_cnt[0]}, 2'b00);
        chk("post_reset_no_shift", en_cnt, 0);

`ifdef CFG_READBACK_EN
        begin
            logic [CL-1:0] prev_a, prev_b;
            logic [15:0]   exp_sig;
            logic [15:0]   held;
            prev_a = chain_a;
            prev_b = chain_b;
            do_load("rb_first", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            exp_sig = 16'hFFFF;
            for (int j = 0; j < CL; j++) begin
                exp_sig = crc_bit(exp_sig, prev_a[CL-1-j]);
                exp_sig = crc_bit(exp_sig, prev_b[CL-1-j]);
            end
            chk("rb_first_sig", sig, exp_sig);
            held = sig;
            for (int i = 0; i < 3; i++) step();
            chk("rb_sig_stable", sig, exp_sig);

            arm(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
            start = 1'b1;
            step();
            start = 1'b0;
            chk("rb_sig_init", sig, 16'hFFFF);
            run_until_done("rb_second");
            exp_sig = 16'hFFFF;
            for (int j = 0; j < 2 * CL; j++) exp_sig = crc_bit(exp_sig, 1'b1);
            chk("rb_second_sig", sig, exp_sig);
            chk("rb_second_shifts", en_cnt, CL);
            if (held == 16'h0) step();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
